// File: rtl/clk_ctrl_pkg.sv
// Shared state encoding and default timing for the clock time-setting controller.
package clk_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_SET_HOUR = 2'd1,
    ST_SET_MIN  = 2'd2,
    ST_ILLEGAL  = 2'd3
  } state_e;

  // Defaults assume a 50 MHz clk.
  localparam int unsigned DEF_HOLD_CYC    = 32'd25_000_000;
  localparam int unsigned DEF_REPEAT_CYC  = 32'd5_000_000;
  localparam int unsigned DEF_TIMEOUT_CYC = 32'd500_000_000;

endpackage

// File: rtl/btn_repeat.sv
// Auto-repeat strobe generator: one strobe on press, a second after HOLD_CYC, then every
// REPEAT_CYC while the button stays held and the block is enabled.
module btn_repeat #(
  parameter int unsigned HOLD_CYC   = 8,
  parameter int unsigned REPEAT_CYC = 4
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic enable_i,
  input  logic btn_i,
  input  logic btn_rise_i,
  output logic rep_strobe_o
);

  localparam int unsigned MaxCyc = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
  localparam int unsigned CntW = $clog2(MaxCyc);
  localparam logic [CntW-1:0] HoldLast = CntW'(HOLD_CYC - 1);
  localparam logic [CntW-1:0] RepLast  = CntW'(REPEAT_CYC - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            active_q, active_d;
  logic            hold_q, hold_d;

  always_comb begin
    cnt_d        = cnt_q;
    active_d     = active_q;
    hold_d       = hold_q;
    rep_strobe_o = 1'b0;
    if (!enable_i || !btn_i) begin
      cnt_d    = '0;
      active_d = 1'b0;
      hold_d   = 1'b0;
    end else if (btn_rise_i) begin
      rep_strobe_o = 1'b1;
      cnt_d        = '0;
      active_d     = 1'b1;
      hold_d       = 1'b1;
    end else if (active_q) begin
      // Only a press seen while enabled arms repeating; a level carried in stays idle.
      if (cnt_q == (hold_q ? HoldLast : RepLast)) begin
        rep_strobe_o = 1'b1;
        cnt_d        = '0;
        hold_d       = 1'b0;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q    <= '0;
      active_q <= 1'b0;
      hold_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      active_q <= active_d;
      hold_q   <= hold_d;
    end
  end

endmodule

// File: rtl/clock_set_ctrl.sv
// Time-setting controller: sequences RUN / SET_HOUR / SET_MIN on MODE presses and issues
// registered increment and seconds-clear strobes, with an inactivity timeout back to RUN.
module clock_set_ctrl
  import clk_ctrl_pkg::*;
#(
  parameter int unsigned HOLD_CYC    = DEF_HOLD_CYC,
  parameter int unsigned REPEAT_CYC  = DEF_REPEAT_CYC,
  parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic btn_mode_i,
  input  logic btn_inc_i,
  output logic run_en_o,
  output logic set_hour_o,
  output logic set_min_o,
  output logic inc_hour_o,
  output logic inc_min_o,
  output logic sec_clr_o
);

  localparam int unsigned TmoW = $clog2(TIMEOUT_CYC);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYC - 1);

  state_e          state_q, state_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            btn_mode_q, btn_inc_q;
  logic            mode_rise, inc_rise, in_set, rep_strobe;
  logic            sec_clr_d;

  assign mode_rise = btn_mode_i & ~btn_mode_q;
  assign inc_rise  = btn_inc_i & ~btn_inc_q;
  assign in_set    = (state_q == ST_SET_HOUR) || (state_q == ST_SET_MIN);

  // A MODE press in the same cycle suppresses the INC strobe and drops any repeat.
  btn_repeat #(
    .HOLD_CYC  (HOLD_CYC),
    .REPEAT_CYC(REPEAT_CYC)
  ) u_btn_repeat (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .enable_i    (in_set & ~mode_rise),
    .btn_i       (btn_inc_i),
    .btn_rise_i  (inc_rise),
    .rep_strobe_o(rep_strobe)
  );

  always_comb begin
    state_d   = state_q;
    tmo_d     = tmo_q;
    sec_clr_d = 1'b0;
    case (state_q)
      ST_RUN: begin
        tmo_d = '0;
        if (mode_rise) state_d = ST_SET_HOUR;
      end
      ST_SET_HOUR, ST_SET_MIN: begin
        if (mode_rise) begin
          state_d   = (state_q == ST_SET_HOUR) ? ST_SET_MIN : ST_RUN;
          sec_clr_d = (state_q == ST_SET_MIN);
          tmo_d     = '0;
        end else if (btn_inc_i) begin
          tmo_d = '0;
        end else if (tmo_q == TmoLast) begin
          state_d   = ST_RUN;
          sec_clr_d = 1'b1;
          tmo_d     = '0;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end
      default: begin
        state_d = ST_RUN;
        tmo_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= ST_RUN;
      tmo_q      <= '0;
      btn_mode_q <= 1'b1;
      btn_inc_q  <= 1'b1;
      run_en_o   <= 1'b1;
      set_hour_o <= 1'b0;
      set_min_o  <= 1'b0;
      inc_hour_o <= 1'b0;
      inc_min_o  <= 1'b0;
      sec_clr_o  <= 1'b0;
    end else begin
      state_q    <= state_d;
      tmo_q      <= tmo_d;
      btn_mode_q <= btn_mode_i;
      btn_inc_q  <= btn_inc_i;
      run_en_o   <= (state_d == ST_RUN);
      set_hour_o <= (state_d == ST_SET_HOUR);
      set_min_o  <= (state_d == ST_SET_MIN);
      inc_hour_o <= rep_strobe & (state_q == ST_SET_HOUR);
      inc_min_o  <= rep_strobe & (state_q == ST_SET_MIN);
      sec_clr_o  <= sec_clr_d;
    end
  end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Bench for clock_set_ctrl: directed scenarios plus random button activity, every cycle
// checked against a time-stamp based reference model.
module tb_clock_set_ctrl;

  localparam int unsigned HOLD = 8;
  localparam int unsigned REP  = 4;
  localparam int unsigned TMO  = 32;
  localparam int M_RUN  = 0;
  localparam int M_HOUR = 1;
  localparam int M_MIN  = 2;

  logic clk = 1'b0;
  logic reset, btn_mode, btn_inc;
  logic run_en, set_hour, set_min, inc_hour, inc_min, sec_clr;

  always #5 clk = ~clk;

  clock_set_ctrl #(
    .HOLD_CYC   (HOLD),
    .REPEAT_CYC (REP),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clk_i     (clk),
    .reset_i   (reset),
    .btn_mode_i(btn_mode),
    .btn_inc_i (btn_inc),
    .run_en_o  (run_en),
    .set_hour_o(set_hour),
    .set_min_o (set_min),
    .inc_hour_o(inc_hour),
    .inc_min_o (inc_min),
    .sec_clr_o (sec_clr)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int t       = 0;
  int cnt_h, cnt_m, cnt_s;

  // Reference model: schedule of due strobe times and time of last activity.
  int         m_st;
  bit         m_pm, m_pi;
  int         due, last_act;
  logic [5:0] exp_o;

  task automatic model_step();
    bit mr, ir, strobe, tmo;
    int old;
    if (reset) begin
      m_st = M_RUN; m_pm = 1'b1; m_pi = 1'b1; due = -1; last_act = t;
      exp_o = 6'b100000;
      return;
    end
    mr = btn_mode && !m_pm;
    ir = btn_inc && !m_pi;
    strobe = 1'b0; tmo = 1'b0; old = m_st;
    if (m_st == M_RUN) begin
      due = -1; last_act = t;
      if (mr) m_st = M_HOUR;
    end else if (mr) begin
      m_st = (old == M_HOUR) ? M_MIN : M_RUN;
      due = -1; last_act = t;
    end else if (btn_inc) begin
      last_act = t;
      if (ir) begin
        strobe = 1'b1; due = t + HOLD;
      end else if (due == t) begin
        strobe = 1'b1; due = t + REP;
      end
    end else begin
      due = -1;
      if (t - last_act >= TMO) begin
        tmo = 1'b1; m_st = M_RUN;
      end
    end
    m_pm = btn_mode; m_pi = btn_inc;
    exp_o = {m_st == M_RUN, m_st == M_HOUR, m_st == M_MIN, strobe && old == M_HOUR,
             strobe && old == M_MIN, tmo || (old == M_MIN && m_st == M_RUN)};
  endtask

  task automatic tick();
    logic [5:0] got;
    @(posedge clk);
    t++;
    model_step();
    #1;
    got = {run_en, set_hour, set_min, inc_hour, inc_min, sec_clr};
    cnt_h += int'(inc_hour);
    cnt_m += int'(inc_min);
    cnt_s += int'(sec_clr);
    n_tests++;
    assert (got === exp_o)
    else begin
      n_fail++;
      $error("FAIL outputs@%0d {run,sh,sm,ih,im,sc} got %b expected %b", t, got, exp_o);
    end
  endtask

  task automatic check_val(input string tag, input int got, input int expv);
    n_tests++;
    assert (got === expv)
    else begin
      n_fail++;
      $error("FAIL %s got %0d expected %0d", tag, got, expv);
    end
  endtask

  task automatic clr_cnt();
    cnt_h = 0; cnt_m = 0; cnt_s = 0;
  endtask

  task automatic press_mode();
    btn_mode = 1'b1; tick();
    btn_mode = 1'b0; tick();
  endtask

  initial begin
    int k;
    reset = 1'b1; btn_mode = 1'b1; btn_inc = 1'b0;
    clr_cnt();
    repeat (3) tick();
    check_val("reset_state", int'({run_en, set_hour, set_min, inc_hour, inc_min, sec_clr}),
              int'(6'b100000));
    // MODE held through reset must not count as a press.
    reset = 1'b0;
    repeat (3) tick();
    check_val("held_mode_no_event", int'(set_hour), 0);
    btn_mode = 1'b0; tick();
    btn_mode = 1'b1; tick();
    check_val("enter_set_hour", int'({run_en, set_hour}), int'(2'b01));
    btn_mode = 1'b0; tick();

    // Short INC pulses in SET_HOUR.
    clr_cnt();
    btn_inc = 1'b1; repeat (3) tick();
    btn_inc = 1'b0; repeat (2) tick();
    check_val("pulse1_inc_hour", cnt_h, 1);
    check_val("pulse1_inc_min", cnt_m, 0);
    btn_inc = 1'b1; repeat (3) tick();
    btn_inc = 1'b0; repeat (2) tick();
    check_val("pulse2_inc_hour", cnt_h, 2);

    // Auto-repeat in SET_MIN.
    press_mode();
    clr_cnt();
    btn_inc = 1'b1; repeat (21) tick();
    check_val("repeat_strobes", cnt_m, 5);
    btn_inc = 1'b0; repeat (10) tick();
    check_val("no_strobe_after_release", cnt_m, 5);
    press_mode();
    check_val("back_to_run", int'(run_en), 1);

    // Three MODE presses from RUN.
    clr_cnt();
    press_mode(); press_mode(); press_mode();
    check_val("three_press_sec_clr", cnt_s, 1);
    check_val("three_press_run", int'(run_en), 1);

    // Simultaneous MODE and INC rise in SET_HOUR.
    press_mode();
    clr_cnt();
    btn_mode = 1'b1; btn_inc = 1'b1; tick();
    check_val("simul_state_min", int'(set_min), 1);
    btn_mode = 1'b0; repeat (15) tick();
    check_val("simul_no_strobes", cnt_h + cnt_m, 0);
    btn_inc = 1'b0; tick();
    press_mode();

    // Inactivity timeout from SET_HOUR.
    clr_cnt();
    btn_mode = 1'b1; tick();
    btn_mode = 1'b0;
    k = 0;
    while (run_en !== 1'b1 && k < 100) begin
      tick(); k++;
    end
    check_val("timeout_cycles", k, TMO);
    check_val("timeout_sec_clr", cnt_s, 1);

    // Reset in the middle of auto-repeat.
    press_mode();
    btn_inc = 1'b1; repeat (12) tick();
    reset = 1'b1; tick();
    check_val("mid_reset_state", int'({run_en, set_hour, set_min, inc_hour, inc_min, sec_clr}),
              int'(6'b100000));
    reset = 1'b0; repeat (3) tick();
    btn_inc = 1'b0; tick();

    // Random button activity.
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 4) btn_mode = ~btn_mode;
      if (r >= 94) btn_inc = ~btn_inc;
      reset = ($urandom_range(0, 599) == 0);
      tick();
    end
    reset = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
    repeat (2) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
